// File: rtl/signed_seq_divider_pkg.sv
// Shared constants for the signed sequential divider.
// It holds the state encoding, the default operand width and the divide-by-zero quotient pattern.
package signed_seq_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Every quotient bit is set to this value on divide-by-zero, giving all ones.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in one dividend bit, trial-subtract the
// divisor magnitude, then keep the difference or restore the shifted remainder.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           borrow_s;
    logic           unused_msb_s;

    assign shifted_s = {rem_in, shift_in};
    assign {borrow_s, trial_s} = {1'b0, shifted_s} - {2'b00, divisor_mag};
    assign q_bit = ~borrow_s;
    // The result is always below divisor_mag, so bit WIDTH of the trial value is never needed.
    assign rem_out = q_bit ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    assign unused_msb_s = trial_s[WIDTH];

endmodule

// File: rtl/signed_seq_divider.sv
// Iterative signed divider with C (truncating) semantics. It produces one quotient bit per clock
// on magnitudes and fixes the signs in a final cycle.
module signed_seq_divider
    import signed_seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    div_state_e      state_r, state_next_s;
    logic [CW-1:0]   count_r, count_next_s;
    logic [WIDTH-1:0] prem_r, prem_next_s;
    logic [WIDTH-1:0] dq_r, dq_next_s;
    logic [WIDTH-1:0] dvs_r, dvs_next_s;
    logic            neg_q_r, neg_q_next_s;
    logic            neg_r_r, neg_r_next_s;
    logic            busy_r, busy_next_s;
    logic            done_r, done_next_s;
    logic            dbz_r, dbz_next_s;
    logic [WIDTH-1:0] quot_r, quot_next_s;
    logic [WIDTH-1:0] rem_r, rem_next_s;
    logic [WIDTH-1:0] step_rem_s;
    logic            step_q_s;

    // dq_r starts as the dividend magnitude and fills with quotient bits from the right as it drains.
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (prem_r),
        .shift_in    (dq_r[WIDTH-1]),
        .divisor_mag (dvs_r),
        .rem_out     (step_rem_s),
        .q_bit       (step_q_s)
    );

    // Next-state and next-datapath logic; every register holds unless its state updates it.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        prem_next_s  = prem_r;
        dq_next_s    = dq_r;
        dvs_next_s   = dvs_r;
        neg_q_next_s = neg_q_r;
        neg_r_next_s = neg_r_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        dbz_next_s   = dbz_r;
        quot_next_s  = quot_r;
        rem_next_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == ZERO_W) begin
                        quot_next_s = {WIDTH{DBZ_QUOTIENT_BIT}};
                        rem_next_s  = dividend;
                        dbz_next_s  = 1'b1;
                        done_next_s = 1'b1;
                    end else begin
                        neg_q_next_s = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_next_s = dividend[WIDTH-1];
                        dq_next_s    = dividend[WIDTH-1] ? (ZERO_W - dividend) : dividend;
                        dvs_next_s   = divisor[WIDTH-1] ? (ZERO_W - divisor) : divisor;
                        prem_next_s  = ZERO_W;
                        count_next_s = {CW{1'b0}};
                        busy_next_s  = 1'b1;
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                prem_next_s  = step_rem_s;
                dq_next_s    = {dq_r[WIDTH-2:0], step_q_s};
                count_next_s = count_r + CNT_ONE;
                if (count_r == CNT_LAST) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX: begin
                quot_next_s  = neg_q_r ? (ZERO_W - dq_r) : dq_r;
                rem_next_s   = neg_r_r ? (ZERO_W - prem_r) : prem_r;
                dbz_next_s   = 1'b0;
                done_next_s  = 1'b1;
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered-output update; reset discards any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            prem_r  <= ZERO_W;
            dq_r    <= ZERO_W;
            dvs_r   <= ZERO_W;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            quot_r  <= ZERO_W;
            rem_r   <= ZERO_W;
        end else begin
            count_r <= count_next_s;
            prem_r  <= prem_next_s;
            dq_r    <= dq_next_s;
            dvs_r   <= dvs_next_s;
            neg_q_r <= neg_q_next_s;
            neg_r_r <= neg_r_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            dbz_r   <= dbz_next_s;
            quot_r  <= quot_next_s;
            rem_r   <= rem_next_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quot_r;
    assign remainder   = rem_r;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard testbench for signed_seq_divider: the driver pushes reference results and a
// monitor pops and checks them on every done pulse, together with latency and output stability.
module tb_signed_seq_divider;

    localparam int W = 32;
    localparam int LAT = W + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_d = 1'b0;

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain C-style signed division on 64-bit integers, truncated to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
        exp_t   e;
        longint sa, sbv, qq, rr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.due = due;
        if (sbv == 0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            qq = sa / sbv;
            rr = sa % sbv;
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        sb.push_back(model(a, b, (b == '0) ? cyc : cyc + LAT));
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", n, LAT);
        end
    endtask

    // Monitor: check each done against the scoreboard; outputs must hold between results.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_q = '0;
            last_r = '0;
            last_d = 1'b0;
        end else if (done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no result", cyc);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || cyc != e.due) begin
                    n_err++;
                    $display("FAIL result: got q=%h r=%h dbz=%b cyc=%0d, expected q=%h r=%h dbz=%b cyc=%0d",
                             quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dbz, e.due);
                end
            end
            last_q = quotient;
            last_r = remainder;
            last_d = div_by_zero;
        end else begin
            n_cmp++;
            if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_d) begin
                n_err++;
                $display("FAIL hold: got q=%h r=%h dbz=%b without done, expected q=%h r=%h dbz=%b",
                         quotient, remainder, div_by_zero, last_q, last_r, last_d);
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL latency: got no done at cycle %0d, expected done at cycle %0d", cyc, e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int pick;
        logic [W-1:0] a, b;

        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 100 / 7 with busy-window measurement
        do_op(32'd100, 32'd7);
        busy_cnt = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        check("busy_cycles", busy_cnt, 32'd33);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        tick();

        do_op(-32'sd100, 32'd7);   wait_done(); tick();
        do_op(32'd100, -32'sd7);   wait_done(); tick();
        do_op(-32'sd100, -32'sd7); wait_done(); tick();
        do_op(32'h8000_0000, 32'hFFFF_FFFF); wait_done(); tick();

        // divide by zero: done already visible one cycle after the accept edge, busy never rises
        do_op(32'd1234, 32'd0);
        check("dbz_done", {31'd0, done}, 32'd1);
        check("dbz_busy", {31'd0, busy}, 32'd0);
        tick();
        check("dbz_busy_after", {31'd0, busy}, 32'd0);
        tick();

        // start while busy is ignored
        do_op(32'd50, 32'd5);
        repeat (9) tick();
        pulse_start(32'd9, 32'd3);
        wait_done();
        tick();

        // reset in the middle of a division
        do_op(32'd1000, 32'd3);
        repeat (19) tick();
        sb.delete();
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (40) tick();
        do_op(32'd9, 32'd3);
        wait_done();

        // back-to-back: new start in the done cycle
        do_op(32'd7, 32'd2);
        wait_done();

        // randomized traffic with occasional ignored starts and back-to-back issue
        for (int k = 0; k < 60; k++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            pick = $urandom_range(0, 9);
            if (pick == 0) b = 32'd0;
            else if (pick == 1) b = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            else if (pick < 5) b = $unsigned(32'($signed($urandom_range(0, 40)) - 32'sd20));
            else b = $urandom;
            do_op(a, b);
            if (b != 32'd0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 25)) tick();
                pulse_start($urandom, $urandom);
            end
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
